// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation datapath: Montgomery
// multiplier FSM encoding and counter sizing helper.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2
  } mmm_state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: acc' = (acc + a_i*B + q*N) / 2,
// with q chosen so the sum is even. Purely combinational.
module mmm_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH+1:0] acc,
  input  logic             a_i,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH+1:0] acc_next
);

  logic [WIDTH+1:0] s;
  logic [WIDTH+1:0] t;

  // Two guard bits keep acc + B + N (< 4N) from overflowing.
  assign s        = acc + (a_i ? {2'b00, B} : '0);
  assign t        = s + (s[0] ? {2'b00, N} : '0);
  assign acc_next = t >> 1;

endmodule

// File: rtl/mmm_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod N,
// WIDTH iteration cycles followed by one final-subtraction cycle.
module mmm_radix2
  import rsa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mmm_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH+1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic [WIDTH+1:0] acc_step;
  logic             acc_ge_n;
  logic [WIDTH-1:0] acc_minus_n;

  mmm_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_reg),
    .a_i      (a_reg[cnt_reg]),
    .B        (b_reg),
    .N        (n_reg),
    .acc_next (acc_step)
  );

  // acc < 2N after the last iteration, so one conditional subtract suffices.
  assign acc_ge_n    = acc_reg[WIDTH:0] >= {1'b0, n_reg};
  assign acc_minus_n = acc_reg[WIDTH-1:0] - n_reg;

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    n_next      = n_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    done_next   = done_reg;
    result_next = result_reg;

    if (!clear) begin
      state_next  = IDLE;
      done_next   = 1'b0;
      result_next = '0;
      acc_next    = '0;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_next = 1'b0;
          if (start) begin
            a_next     = A;
            b_next     = B;
            n_next     = N;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = ITER;
          end
        end
        ITER: begin
          acc_next = acc_step;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next = SUB;
          end
        end
        SUB: begin
          result_next = acc_ge_n ? acc_minus_n : acc_reg[WIDTH-1:0];
          done_next   = 1'b1;
          state_next  = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      n_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (ena) begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      n_reg      <= n_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mmm_radix2.sv
// Self-checking bench for mmm_radix2: directed WIDTH=4 vectors and control
// sequences, plus randomized WIDTH=8 products against a modular-arithmetic model.
module tb_mmm_radix2;

  logic       clk = 1'b0;
  logic       rstb, ena, clear;
  logic       start4, start8;
  logic [3:0] a4, b4, n4;
  logic [7:0] a8, b8, n8;
  logic       busy4, done4, busy8, done8;
  logic [3:0] result4;
  logic [7:0] result8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmm_radix2 #(.WIDTH(4)) dut4 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start4),
    .A(a4), .B(b4), .N(n4), .busy(busy4), .done(done4), .result(result4)
  );

  mmm_radix2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start8),
    .A(a8), .B(b8), .N(n8), .busy(busy8), .done(done8), .result(result8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] n;
    logic [3:0] exp_result;
  } vec_t;

  vec_t vecs[4];

  // Reference: (A*B mod N) * (2^W)^-1 mod N, inverse found by search.
  function automatic longint mont_ref(input longint a, input longint b,
                                      input longint n, input int w);
    longint r, rinv;
    r    = (longint'(1) << w) % n;
    rinv = 0;
    for (longint x = 0; x < n; x++) begin
      if ((r * x) % n == 1) rinv = x;
    end
    return (((a * b) % n) * rinv) % n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
    a4 = a; b4 = b; n4 = n; start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    a8 = a; b8 = b; n8 = n; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Counts cycles after the start edge until done; bounded so a hung DUT
  // shows up as a latency mismatch.
  task automatic wait_done4(input int lat0, output int lat, output int busy_cnt);
    lat = lat0;
    busy_cnt = 0;
    while (lat < 40) begin
      if (busy4) busy_cnt++;
      if (done4) break;
      tick();
      lat++;
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (lat < 40) begin
      if (done8) break;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc, seen;
    logic [7:0] ra, rb, rn;

    vecs[0] = '{a: 4'd5,  b: 4'd7,  n: 4'd13, exp_result: 4'd3};
    vecs[1] = '{a: 4'd14, b: 4'd14, n: 4'd15, exp_result: 4'd1};
    vecs[2] = '{a: 4'd0,  b: 4'd12, n: 4'd13, exp_result: 4'd0};
    vecs[3] = '{a: 4'd12, b: 4'd12, n: 4'd13, exp_result: 4'd9};

    rstb = 1'b0; ena = 1'b1; clear = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; n4 = '0; a8 = '0; b8 = '0; n8 = '0;
    #1;
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_result", result4, 0);
    check("reset_result8", result8, 0);
    tick();
    tick();
    rstb = 1'b1;
    tick();
    $display("reset: busy=%0d done=%0d result=%0d", busy4, done4, result4);

    foreach (vecs[i]) begin
      start_op4(vecs[i].a, vecs[i].b, vecs[i].n);
      wait_done4(0, lat, bc);
      $display("vec%0d: A=%0d B=%0d N=%0d -> result=%0d latency=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].n, result4, lat);
      check("vec_result", result4, vecs[i].exp_result);
      check("vec_latency", lat, 5);
      check("vec_busy_cycles", bc, 5);
      tick();
      check("vec_done_pulse", done4, 0);
    end

    // Back-to-back: second start lands in the done cycle.
    start_op4(4'd5, 4'd7, 4'd13);
    wait_done4(0, lat, bc);
    check("b2b_first", result4, 3);
    start_op4(4'd12, 4'd12, 4'd13);
    check("b2b_accepted", busy4, 1);
    wait_done4(0, lat, bc);
    $display("b2b: second result=%0d latency=%0d", result4, lat);
    check("b2b_second", result4, 9);
    check("b2b_latency", lat, 5);

    // start while busy is ignored.
    start_op4(4'd5, 4'd7, 4'd13);
    tick();
    tick();
    a4 = 4'd0; b4 = 4'd0; n4 = 4'd15; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(3, lat, bc);
    $display("start_mid_iter: result=%0d latency=%0d", result4, lat);
    check("midstart_result", result4, 3);
    check("midstart_latency", lat, 5);
    tick();
    check("midstart_no_restart", busy4, 0);

    // ena low for 3 cycles mid-ITER delays done by exactly 3.
    start_op4(4'd12, 4'd12, 4'd13);
    tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    wait_done4(4, lat, bc);
    $display("ena_stall: result=%0d latency=%0d", result4, lat);
    check("stall_result", result4, 9);
    check("stall_latency", lat, 8);
    ena = 1'b0;
    tick();
    tick();
    check("stall_done_held", done4, 1);
    ena = 1'b1;
    tick();
    check("stall_done_drop", done4, 0);

    // clear mid-ITER aborts with no done pulse.
    start_op4(4'd5, 4'd7, 4'd13);
    tick();
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check("clear_busy", busy4, 0);
    check("clear_result", result4, 0);
    seen = 0;
    repeat (10) begin
      if (done4) seen = 1;
      tick();
    end
    $display("clear_mid_iter: busy=%0d result=%0d done_seen=%0d", busy4, result4, seen);
    check("clear_no_done", seen, 0);

    // Async reset mid-operation, then a normal operation.
    start_op4(4'd5, 4'd7, 4'd13);
    wait_done4(0, lat, bc);
    check("prereset_result", result4, 3);
    start_op4(4'd12, 4'd12, 4'd13);
    tick();
    tick();
    rstb = 1'b0;
    #1;
    check("midreset_busy", busy4, 0);
    check("midreset_done", done4, 0);
    check("midreset_result", result4, 0);
    tick();
    rstb = 1'b1;
    tick();
    start_op4(4'd14, 4'd14, 4'd15);
    wait_done4(0, lat, bc);
    $display("after_reset: result=%0d latency=%0d", result4, lat);
    check("postreset_result", result4, 1);
    check("postreset_latency", lat, 5);

    // Randomized WIDTH=8 against the arithmetic model.
    for (int t = 0; t < 1000; t++) begin
      rn = 8'($urandom_range(1, 127) * 2 + 1);
      ra = 8'($urandom_range(0, int'(rn) - 1));
      rb = 8'($urandom_range(0, int'(rn) - 1));
      start_op8(ra, rb, rn);
      wait_done8(lat);
      $display("rand%0d: A=%0d B=%0d N=%0d -> result=%0d latency=%0d",
               t, ra, rb, rn, result8, lat);
      check("rand_result", result8, mont_ref(ra, rb, rn, 8));
      check("rand_latency", lat, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmm_radix2.md
Name: mmm_radix2

Overview:
- Bit-serial radix-2 Montgomery modular multiplier. Computes result = A·B·2^-WIDTH mod N.
- Sits directly upstream of the R_i shift/hold register in the RSA exponentiation datapath.
- Its result drives that register's reg_rji input. Its done pulse gates the register's ld_r/lock sequencing.
- One multiplication is WIDTH iterations plus one final-subtraction cycle.

Parameters:
- WIDTH, 4, operand/modulus width in bits. Minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstb  input  1  asynchronous active-low reset
- ena  input  1  global clock enable. When 0, every register holds, including done.
- clear  input  1  synchronous active-low abort/clear. Effective only when ena=1.
- start  input  1  request a multiplication. Sampled in IDLE with ena=1.
- A  input  WIDTH  multiplier operand, must be < N
- B  input  WIDTH  multiplicand operand, must be < N
- N  input  WIDTH  modulus, must be odd
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse when result is updated
- result  output  WIDTH  Montgomery product, holds until next done or clear

Behaviour:
- Reset (rstb=0, async):
  - state=IDLE; busy=0; done=0; result=0.
  - Internal A/B/N copies, accumulator and counter are all 0.
- Priority each rising edge: rstb, then ena=0 (hold all), then clear=0, then the FSM.
- clear=0 with ena=1:
  - state=IDLE, done=0, result=0, accumulator=0, counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: done<=0. If start=1:
    - latch A, B, N into internal registers;
    - acc<=0, cnt<=0;
    - go to ITER.
  - ITER, iteration i = cnt, with a_i = latched A bit i (LSB first):
    - s = acc + (a_i ? B : 0);
    - q = s[0];
    - acc <= (s + (q ? N : 0)) >> 1.
    - cnt increments. Go to SUB after the iteration with cnt = WIDTH-1.
    - Exactly WIDTH ITER cycles.
  - SUB:
    - result <= (acc >= N) ? acc - N : acc[WIDTH-1:0];
    - done<=1; go to IDLE.
- Arithmetic widths:
  - acc and the s + q·N sum are WIDTH+2 bits wide, so there is no overflow (max < 4N).
  - acc < 2N holds after every iteration, so one conditional subtraction suffices.
  - The comparison and subtraction are done at WIDTH+1 bits.
- Latency and handshake:
  - start sampled at edge k; done is high during the cycle after edge k+WIDTH+1.
  - busy is high after edges k .. k+WIDTH and low in the same cycle that done is high.
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the done cycle (state IDLE) is accepted; back-to-back operations have no bubble beyond SUB.
  - A/B/N may change after the start edge without effect.
- ena=0 mid-operation: FSM, cnt, acc and done freeze. Resuming ena=1 continues exactly; total enabled-cycle latency is unchanged.
- Out-of-contract inputs (N even, A or B ≥ N): no hang. FSM still completes in WIDTH+1 cycles; result value is unspecified.
- Counter width: $clog2(WIDTH). Terminal compare is against WIDTH-1.

Decomposition:
- Shared rsa_pkg holds:
  - the FSM state enum (IDLE, ITER, SUB), 2-bit encoding;
  - a localparam helper for counter width.
- One natural sub-module, mmm_step: purely combinational single iteration.
  - Inputs: acc, a_i, B, N.
  - Output: next acc.
  - It is reusable by a future radix-4 variant.
- Top contains the FSM, registers and the final subtractor.

Test Plan:
- Basic, WIDTH=4: A=5, B=7, N=13, pulse start -> done exactly 5 cycles later, result=3 (5·7·9 mod 13, 2^-4 ≡ 9). busy high 5 cycles.
- Final subtraction, WIDTH=4: A=14, B=14, N=15 -> pre-subtraction acc=16, result=1. Confirm the SUB branch is taken (coverage point).
- Edge values, WIDTH=4:
  - A=0, B=12, N=13 -> result=0.
  - A=12, B=12, N=13 -> result=9.
  - Back-to-back: start asserted in the done cycle is accepted, and the second result is correct.
- Control interference:
  - start pulsed mid-ITER -> ignored, first result unchanged.
  - ena=0 for 3 cycles mid-ITER -> done delayed exactly 3 cycles, same result.
  - clear=0 mid-ITER -> IDLE, result=0, no done pulse.
- Reset mid-operation: rstb low during ITER -> immediately busy=0, done=0, result=0. A new start after release completes normally.
- Random: WIDTH=8, 1000 random odd N with A, B < N -> result matches the reference model A·B·inv(256) mod N. Latency is always 9 cycles.
